// File: rtl/cursor_nav_if.sv
// -----------------------------------------------------------------------------
// cursor_nav_if
// Bundles the button inputs and cursor outputs of cursor_nav.
//   move[3:0]  raw direction buttons, active-low (master -> slave)
//   home_n     raw home button, active-low (only with CURSOR_HOME_EN)
//   cursor_x   current column (slave -> master)
//   cursor_y   current row    (slave -> master)
//   moved      one-cycle redraw strobe (slave -> master)
// Modports: master = button/board side, slave = cursor_nav.
// Optional feature macro: CURSOR_HOME_EN adds home_n.
// -----------------------------------------------------------------------------
interface cursor_nav_if #(
  parameter int XW = 8,
  parameter int YW = 8
);
  logic [3:0]    move;
  logic [XW-1:0] cursor_x;
  logic [YW-1:0] cursor_y;
  logic          moved;
`ifdef CURSOR_HOME_EN
  logic          home_n;

  modport master (output move, output home_n,
                  input cursor_x, input cursor_y, input moved);
  modport slave  (input move, input home_n,
                  output cursor_x, output cursor_y, output moved);
`else
  modport master (output move,
                  input cursor_x, input cursor_y, input moved);
  modport slave  (input move,
                  output cursor_x, output cursor_y, output moved);
`endif
endinterface

// File: rtl/cursor_nav.sv
// -----------------------------------------------------------------------------
// cursor_nav
// Turns four raw active-low direction buttons into board cursor coordinates
// for the Game-of-Life editor: 2-flop synchronisation, one step per press,
// hold-to-auto-repeat, diagonal steps, opposing-press cancel, and wrap or
// clamp at the board edges.
// Ports:
//   clk          clock
//   rst          asynchronous, active-low reset
//   bus (slave)  move[3:0] in  : [0] x-1, [1] y+1, [2] y-1, [3] x+1 (active-low)
//                home_n    in  : home button, active-low (CURSOR_HOME_EN only)
//                cursor_x  out : column 0..MAX_X-1
//                cursor_y  out : row 0..MAX_Y-1
//                moved     out : pulse on the cycle after a coordinate changed
// Optional feature macro: CURSOR_HOME_EN. When defined, a synchronised
// falling edge of home_n centres the cursor; holding home_n parks the FSM in
// IDLE and ignores the direction buttons.
// -----------------------------------------------------------------------------
module cursor_nav #(
  parameter int MAX_X        = 64,
  parameter int MAX_Y        = 48,
  parameter int XW           = 8,
  parameter int YW           = 8,
  parameter int REPEAT_DELAY = 12000000,
  parameter int REPEAT_RATE  = 3000000,
  parameter int CNT_W        = 24,
  parameter int WRAP         = 1
) (
  input  logic        clk,
  input  logic        rst,
  cursor_nav_if.slave bus
);

  localparam logic [XW-1:0]    X_LAST     = XW'(MAX_X - 1);
  localparam logic [YW-1:0]    Y_LAST     = YW'(MAX_Y - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  // Synchronisers and prev-set are kept in the raw active-low form, so
  // "released" is all ones.
  logic [3:0]       sync1_q, sync2_q, prev_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic             moved_q, moved_d;

  logic [3:0] prs;
  logic [3:0] prev_prs;
  logic       step;
  logic       inc_x, dec_x, inc_y, dec_y;

`ifdef CURSOR_HOME_EN
  localparam logic [XW-1:0] HOME_X = XW'(MAX_X / 2);
  localparam logic [YW-1:0] HOME_Y = YW'(MAX_Y / 2);

  logic home1_q, home2_q, home_prev_q;
  logic home_fall, home_held;

  assign home_fall = home_prev_q & ~home2_q;
  assign home_held = ~home2_q;
`endif

  assign prs      = ~sync2_q;
  assign prev_prs = ~prev_q;

  // Opposing buttons cancel on their own axis only.
  assign inc_x = prs[3] & ~prs[0];
  assign dec_x = prs[0] & ~prs[3];
  assign inc_y = prs[1] & ~prs[2];
  assign dec_y = prs[2] & ~prs[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step    = 1'b0;

    // Release has priority over everything, including a due repeat.
    if (prs == 4'b0000) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          step    = 1'b1;
          cnt_d   = '0;
          state_d = HOLD;
        end
        HOLD: begin
          if (prs != prev_prs) begin
            step  = 1'b1;
            cnt_d = '0;
          end else if (cnt_q == DELAY_LAST) begin
            step    = 1'b1;
            cnt_d   = '0;
            state_d = REPEAT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        REPEAT: begin
          if (prs != prev_prs) begin
            step    = 1'b1;
            cnt_d   = '0;
            state_d = HOLD;
          end else if (cnt_q == RATE_LAST) begin
            step  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Edges are handled by explicit compares so no overflow is relied upon.
    x_d = x_q;
    y_d = y_q;
    if (step) begin
      if (inc_x) begin
        if (x_q == X_LAST) x_d = (WRAP != 0) ? '0 : x_q;
        else               x_d = x_q + 1'b1;
      end else if (dec_x) begin
        if (x_q == '0) x_d = (WRAP != 0) ? X_LAST : x_q;
        else           x_d = x_q - 1'b1;
      end
      if (inc_y) begin
        if (y_q == Y_LAST) y_d = (WRAP != 0) ? '0 : y_q;
        else               y_d = y_q + 1'b1;
      end else if (dec_y) begin
        if (y_q == '0) y_d = (WRAP != 0) ? Y_LAST : y_q;
        else           y_d = y_q - 1'b1;
      end
    end

`ifdef CURSOR_HOME_EN
    // Home overrides any direction step and parks the FSM while held.
    if (home_fall) begin
      x_d     = HOME_X;
      y_d     = HOME_Y;
      state_d = IDLE;
      cnt_d   = '0;
    end else if (home_held) begin
      x_d     = x_q;
      y_d     = y_q;
      state_d = IDLE;
      cnt_d   = '0;
    end
`endif

    moved_d = (x_d != x_q) || (y_d != y_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 4'b1111;
      sync2_q     <= 4'b1111;
      prev_q      <= 4'b1111;
      state_q     <= IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      moved_q     <= 1'b0;
`ifdef CURSOR_HOME_EN
      home1_q     <= 1'b1;
      home2_q     <= 1'b1;
      home_prev_q <= 1'b1;
`endif
    end else begin
      sync1_q     <= bus.move;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      moved_q     <= moved_d;
`ifdef CURSOR_HOME_EN
      home1_q     <= bus.home_n;
      home2_q     <= home1_q;
      home_prev_q <= home2_q;
`endif
    end
  end

  assign bus.cursor_x = x_q;
  assign bus.cursor_y = y_q;
  assign bus.moved    = moved_q;

endmodule

// File: tb/tb_cursor_nav.sv
// -----------------------------------------------------------------------------
// tb_cursor_nav
// Directed bench for cursor_nav on a 4x3 board (REPEAT_DELAY=10,
// REPEAT_RATE=4). Two instances share the stimulus: dut_w wraps at the
// edges, dut_c clamps. Tick index t counts rising edges after the inputs
// were changed; a press sampled at edge 1 shows up on the cursor after
// edge 3, the first repeat after edge 13, then every 4 edges.
// -----------------------------------------------------------------------------
module tb_cursor_nav;

  localparam int MAX_X = 4;
  localparam int MAX_Y = 3;
  localparam int XW    = 2;
  localparam int YW    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] move_drv = 4'b1111;
  logic       home_drv = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cursor_nav_if #(.XW(XW), .YW(YW)) bw ();
  cursor_nav_if #(.XW(XW), .YW(YW)) bc ();

  assign bw.move = move_drv;
  assign bc.move = move_drv;
`ifdef CURSOR_HOME_EN
  assign bw.home_n = home_drv;
  assign bc.home_n = home_drv;
`endif

  cursor_nav #(.MAX_X(MAX_X), .MAX_Y(MAX_Y), .XW(XW), .YW(YW),
               .REPEAT_DELAY(10), .REPEAT_RATE(4), .CNT_W(4), .WRAP(1))
    dut_w (.clk(clk), .rst(rst), .bus(bw.slave));

  cursor_nav #(.MAX_X(MAX_X), .MAX_Y(MAX_Y), .XW(XW), .YW(YW),
               .REPEAT_DELAY(10), .REPEAT_RATE(4), .CNT_W(4), .WRAP(0))
    dut_c (.clk(clk), .rst(rst), .bus(bc.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Initial step lands at t=3, repeats at t=13 and every 4 after that.
  function automatic bit step_tick(int t);
    return (t == 3) || (t >= 13 && ((t - 13) % 4) == 0);
  endfunction

  task automatic do_reset();
    move_drv = 4'b1111;
    home_drv = 1'b1;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    move_drv = 4'b1111;
    tick();
    tick();
    checks++;
    if ({bw.cursor_x, bw.cursor_y, bw.moved} !== 5'b0) begin
      errors++;
      $display("FAIL reset_wrap: got x=%0d y=%0d moved=%0b, want 0 0 0",
               bw.cursor_x, bw.cursor_y, bw.moved);
    end
    checks++;
    if ({bc.cursor_x, bc.cursor_y, bc.moved} !== 5'b0) begin
      errors++;
      $display("FAIL reset_clamp: got x=%0d y=%0d moved=%0b, want 0 0 0",
               bc.cursor_x, bc.cursor_y, bc.moved);
    end
    rst = 1'b1;
    tick();
    $display("test_reset: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_single_step();
    logic [XW-1:0] ex;
    do_reset();
    move_drv = 4'b0111;               // right, held for 3 sampled edges
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (t == 3) move_drv = 4'b1111;
      ex = (t >= 3) ? 2'd1 : 2'd0;
      checks++;
      if ({bw.cursor_x, bw.cursor_y, bw.moved} !== {ex, 2'd0, (t == 3)}) begin
        errors++;
        $display("FAIL single_step_wrap t=%0d: got x=%0d y=%0d moved=%0b, want x=%0d y=0 moved=%0b",
                 t, bw.cursor_x, bw.cursor_y, bw.moved, ex, (t == 3));
      end
      checks++;
      if ({bc.cursor_x, bc.cursor_y, bc.moved} !== {ex, 2'd0, (t == 3)}) begin
        errors++;
        $display("FAIL single_step_clamp t=%0d: got x=%0d y=%0d moved=%0b, want x=%0d y=0 moved=%0b",
                 t, bc.cursor_x, bc.cursor_y, bc.moved, ex, (t == 3));
      end
    end
    $display("test_single_step: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_hold_left();
    logic [XW-1:0] ex = '0;
    bit st;
    do_reset();
    move_drv = 4'b1110;               // left held from (0,0)
    for (int t = 1; t <= 26; t++) begin
      tick();
      st = step_tick(t);
      if (st) ex = (ex == 2'd0) ? 2'd3 : ex - 2'd1;
      checks++;
      if ({bw.cursor_x, bw.cursor_y, bw.moved} !== {ex, 2'd0, st}) begin
        errors++;
        $display("FAIL hold_left_wrap t=%0d: got x=%0d y=%0d moved=%0b, want x=%0d y=0 moved=%0b",
                 t, bw.cursor_x, bw.cursor_y, bw.moved, ex, st);
      end
      checks++;
      if ({bc.cursor_x, bc.cursor_y, bc.moved} !== 5'b0) begin
        errors++;
        $display("FAIL hold_left_clamp t=%0d: got x=%0d y=%0d moved=%0b, want 0 0 0",
                 t, bc.cursor_x, bc.cursor_y, bc.moved);
      end
    end
    $display("test_hold_left: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_hold_down_edge();
    logic [YW-1:0] ey = '0;
    bit st;
    do_reset();
    move_drv = 4'b1011;               // y-1 held at y=0
    for (int t = 1; t <= 30; t++) begin
      tick();
      st = step_tick(t);
      if (st) ey = (ey == 2'd0) ? 2'd2 : ey - 2'd1;
      checks++;
      if ({bc.cursor_x, bc.cursor_y, bc.moved} !== 5'b0) begin
        errors++;
        $display("FAIL clamp_y0 t=%0d: got x=%0d y=%0d moved=%0b, want 0 0 0",
                 t, bc.cursor_x, bc.cursor_y, bc.moved);
      end
      checks++;
      if ({bw.cursor_x, bw.cursor_y, bw.moved} !== {2'd0, ey, st}) begin
        errors++;
        $display("FAIL wrap_y0 t=%0d: got x=%0d y=%0d moved=%0b, want x=0 y=%0d moved=%0b",
                 t, bw.cursor_x, bw.cursor_y, bw.moved, ey, st);
      end
    end
    $display("test_hold_down_edge: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_cancel();
    logic [YW-1:0] ey;
    do_reset();
    move_drv = 4'b0100;               // left + right + y+1
    for (int t = 1; t <= 22; t++) begin
      tick();
      if (t == 5) move_drv = 4'b0110; // drop y+1, keep left + right
      ey = (t >= 3) ? 2'd1 : 2'd0;
      checks++;
      if ({bw.cursor_x, bw.cursor_y, bw.moved} !== {2'd0, ey, (t == 3)}) begin
        errors++;
        $display("FAIL cancel_wrap t=%0d: got x=%0d y=%0d moved=%0b, want x=0 y=%0d moved=%0b",
                 t, bw.cursor_x, bw.cursor_y, bw.moved, ey, (t == 3));
      end
      checks++;
      if ({bc.cursor_x, bc.cursor_y, bc.moved} !== {2'd0, ey, (t == 3)}) begin
        errors++;
        $display("FAIL cancel_clamp t=%0d: got x=%0d y=%0d moved=%0b, want x=0 y=%0d moved=%0b",
                 t, bc.cursor_x, bc.cursor_y, bc.moved, ey, (t == 3));
      end
    end
    $display("test_cancel: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_set_change();
    logic [XW-1:0] ex;
    logic [YW-1:0] ey;
    bit em;
    do_reset();
    move_drv = 4'b0111;               // right
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (t == 5) move_drv = 4'b0101; // add y+1 -> immediate diagonal at t=8
      ex = (t >= 18) ? 2'd3 : (t >= 8) ? 2'd2 : (t >= 3) ? 2'd1 : 2'd0;
      ey = (t >= 18) ? 2'd2 : (t >= 8) ? 2'd1 : 2'd0;
      em = (t == 3) || (t == 8) || (t == 18);
      checks++;
      if ({bw.cursor_x, bw.cursor_y, bw.moved} !== {ex, ey, em}) begin
        errors++;
        $display("FAIL set_change t=%0d: got x=%0d y=%0d moved=%0b, want x=%0d y=%0d moved=%0b",
                 t, bw.cursor_x, bw.cursor_y, bw.moved, ex, ey, em);
      end
    end
    $display("test_set_change: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_release_priority();
    logic [XW-1:0] ex;
    do_reset();
    move_drv = 4'b0111;               // right
    for (int t = 1; t <= 18; t++) begin
      tick();
      // Release reaches the FSM at edge 13, the same edge the repeat is due.
      if (t == 10) move_drv = 4'b1111;
      ex = (t >= 3) ? 2'd1 : 2'd0;
      checks++;
      if ({bw.cursor_x, bw.cursor_y, bw.moved} !== {ex, 2'd0, (t == 3)}) begin
        errors++;
        $display("FAIL release_priority t=%0d: got x=%0d y=%0d moved=%0b, want x=%0d y=0 moved=%0b",
                 t, bw.cursor_x, bw.cursor_y, bw.moved, ex, (t == 3));
      end
    end
    $display("test_release_priority: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_reset_mid_hold();
    logic [YW-1:0] ey = '0;
    bit st;
    do_reset();
    move_drv = 4'b1101;               // y+1 held
    for (int t = 1; t <= 15; t++) begin
      tick();
      st = step_tick(t);
      if (st) ey = (ey == 2'd2) ? 2'd0 : ey + 2'd1;
      checks++;
      if ({bw.cursor_y, bw.moved} !== {ey, st}) begin
        errors++;
        $display("FAIL pre_reset_hold t=%0d: got y=%0d moved=%0b, want y=%0d moved=%0b",
                 t, bw.cursor_y, bw.moved, ey, st);
      end
    end
    rst = 1'b0;                        // asynchronous, mid-cycle
    #1;
    checks++;
    if ({bw.cursor_x, bw.cursor_y, bw.moved} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset: got x=%0d y=%0d moved=%0b, want 0 0 0",
               bw.cursor_x, bw.cursor_y, bw.moved);
    end
    tick();                            // edge 16 with reset held
    rst = 1'b1;
    // First edge after deassert is 17; press seen fresh -> step at 19, repeat at 29.
    for (int t = 17; t <= 31; t++) begin
      tick();
      ey = (t >= 29) ? 2'd2 : (t >= 19) ? 2'd1 : 2'd0;
      checks++;
      if ({bw.cursor_x, bw.cursor_y, bw.moved} !== {2'd0, ey, (t == 19 || t == 29)}) begin
        errors++;
        $display("FAIL post_reset_hold t=%0d: got x=%0d y=%0d moved=%0b, want x=0 y=%0d moved=%0b",
                 t, bw.cursor_x, bw.cursor_y, bw.moved, ey, (t == 19 || t == 29));
      end
    end
    $display("test_reset_mid_hold: checks=%0d errors=%0d", checks, errors);
  endtask

`ifdef CURSOR_HOME_EN
  task automatic test_home();
    logic [XW-1:0] ex;
    logic [YW-1:0] ey;
    do_reset();
    move_drv = 4'b1010;               // left + y-1: wrap instance goes to (3,2)
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t == 3) move_drv = 4'b1111;
    end
    checks++;
    if ({bw.cursor_x, bw.cursor_y} !== {2'd3, 2'd2}) begin
      errors++;
      $display("FAIL home_setup: got x=%0d y=%0d, want 3 2", bw.cursor_x, bw.cursor_y);
    end
    move_drv = 4'b0111;               // right and home together
    home_drv = 1'b0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      ex = (t >= 3) ? 2'd2 : 2'd3;
      ey = (t >= 3) ? 2'd1 : 2'd2;
      checks++;
      if ({bw.cursor_x, bw.cursor_y, bw.moved} !== {ex, ey, (t == 3)}) begin
        errors++;
        $display("FAIL home_wrap t=%0d: got x=%0d y=%0d moved=%0b, want x=%0d y=%0d moved=%0b",
                 t, bw.cursor_x, bw.cursor_y, bw.moved, ex, ey, (t == 3));
      end
      ex = (t >= 3) ? 2'd2 : 2'd0;
      ey = (t >= 3) ? 2'd1 : 2'd0;
      checks++;
      if ({bc.cursor_x, bc.cursor_y, bc.moved} !== {ex, ey, (t == 3)}) begin
        errors++;
        $display("FAIL home_clamp t=%0d: got x=%0d y=%0d moved=%0b, want x=%0d y=%0d moved=%0b",
                 t, bc.cursor_x, bc.cursor_y, bc.moved, ex, ey, (t == 3));
      end
    end
    move_drv = 4'b1111;
    home_drv = 1'b1;
    tick();
    $display("test_home: checks=%0d errors=%0d", checks, errors);
  endtask
`endif

  initial begin
    test_reset();
    test_single_step();
    test_hold_left();
    test_hold_down_edge();
    test_cancel();
    test_set_change();
    test_release_priority();
    test_reset_mid_hold();
`ifdef CURSOR_HOME_EN
    test_home();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cursor_nav.md
Name: cursor_nav

Overview:
- Parametrised cursor-navigation block for the Game-of-Life board editor. Converts four raw active-low direction buttons into cursor coordinates.
- Features: input synchronisation, one step per press, hold-to-auto-repeat, diagonal moves, opposing-press cancel, wrap or clamp at board edges.
- Feeds cursor_x/cursor_y to the cell-edit and display logic; `moved` strobes downstream redraw.

Parameters:
- MAX_X, 64, board width in cells (>=2)
- MAX_Y, 48, board height in cells (>=2)
- XW, 8, cursor_x width; 2**XW >= MAX_X
- YW, 8, cursor_y width; 2**YW >= MAX_Y
- REPEAT_DELAY, 12000000, cycles from initial step to first auto-repeat step (>=2)
- REPEAT_RATE, 3000000, cycles between subsequent auto-repeat steps (>=2)
- CNT_W, 24, repeat counter width; holds max(REPEAT_DELAY, REPEAT_RATE)
- WRAP, 1, 1 = wrap at edges, 0 = clamp at edges

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- move  input  4  raw buttons, active-low, asynchronous to clk; [0] left (x-1), [1] y+1, [2] y-1, [3] right (x+1)
- cursor_x  output  XW  current column, 0..MAX_X-1
- cursor_y  output  YW  current row, 0..MAX_Y-1
- moved  output  1  one-cycle pulse on the cycle after either coordinate changes
- home_n  input  1  present only with CURSOR_HOME_EN (see Optional Feature)

Behaviour:
- Reset (rst low, async): cursor_x=0, cursor_y=0, moved=0, FSM=IDLE, counter=0, synchronisers and prev-set = 4'b1111 (released).
- Synchronisation: move passes a 2-flop synchroniser giving s[3:0]. prs = ~s. A prev-set register holds last cycle's prs.
- Step latency: move sampled low at edge k -> new cursor value visible after edge k+2; moved high during the cycle after edge k+2.
- Step vector: dx = prs[3]-prs[0], dy = prs[1]-prs[2].
  - Both opposing buttons held -> 0 on that axis.
  - x and y step in the same cycle (diagonal).
- Edge handling, WRAP=1: 0-1 -> MAX-1; MAX-1+1 -> 0.
- Edge handling, WRAP=0: coordinate holds at 0 / MAX-1.
- moved pulses only if at least one coordinate actually changed. Clamped or cancelled steps give no pulse.
- FSM states: IDLE, HOLD, REPEAT.
  - IDLE: prs != 0 -> apply step, counter=0, go HOLD.
  - HOLD: counter increments each cycle. When counter == REPEAT_DELAY-1 -> step, counter=0, go REPEAT.
  - REPEAT: counter increments. When counter == REPEAT_RATE-1 -> step, counter=0, stay in REPEAT.
  - Any state, prs == 0 -> IDLE, counter=0, no step.
  - HOLD/REPEAT, prs != prev-set and prs != 0 (set changed, e.g. extra button) -> immediate step with the new set, counter=0, go HOLD.
- Timing: first repeat lands exactly REPEAT_DELAY cycles after the initial step; later repeats every REPEAT_RATE cycles.
- Release priority: a release on the same cycle a repeat would fire -> release wins, no step.
- Reset mid-hold: all state returns to reset values. A button still held after reset deasserts is seen as a new press, since prev-set resets to released.
- Arithmetic: done at XW/YW width with explicit compare against MAX-1 and 0. Never relies on natural overflow.

Optional Feature:
- Macro CURSOR_HOME_EN.
- Defined: adds input home_n (active-low, synchronised like move). A synchronised falling edge sets cursor_x=MAX_X/2 and cursor_y=MAX_Y/2 at the same latency as a step. It pulses moved if the position changed, forces FSM to IDLE, and overrides any simultaneous direction step. Holding home_n keeps the FSM in IDLE and ignores move.
- Undefined: no home_n port; no home logic.

Test Plan (MAX_X=4, MAX_Y=3, REPEAT_DELAY=10, REPEAT_RATE=4, CNT_W=4):
- Reset, then pulse move[3] low for 3 cycles, WRAP=1 -> cursor_x 0->1 exactly 2 edges after sampling, one moved pulse, cursor_y=0.
- Hold move[0] low from (0,0), WRAP=1 -> x=3 at initial step, then 2 at +10 cycles, 1 at +14, 0 at +18, 3 at +22; moved pulses at each.
- WRAP=0, hold move[2] at y=0 for 30 cycles -> cursor_y stays 0, moved never asserts, FSM cycles HOLD->REPEAT.
- Hold move[0] and move[3] together plus move[1] -> x unchanged, y 0->1; then release move[1] while still holding left+right -> set-change gives no movement and no moved pulse.
- Hold move[1] in REPEAT, assert rst for 1 cycle mid-hold, keep holding -> cursor returns to (0,0), then y=1 two edges after rst deasserts, next step 10 cycles later.
- CURSOR_HOME_EN: from (3,2), hold move[3] and drop home_n at the same time -> cursor (2,1), one moved pulse, no repeats while home_n is held low.
